// File: rtl/ttt_pkg.sv
// Shared types for the tick-tock-tokens packet front end.
package ttt_pkg;

  localparam int unsigned PKT_W      = 16;
  localparam int unsigned EVT_PROC_W = 4;

  typedef enum logic [3:0] {
    OP_NOP          = 4'b0000,
    OP_INPUT        = 4'b0001,
    OP_ADVANCE      = 4'b0010,
    OP_PROG_DUR     = 4'b1001,
    OP_PROG_GOOD_TH = 4'b1010,
    OP_PROG_BAD_TH  = 4'b1011,
    OP_NET_GOOD     = 4'b1100,
    OP_NET_BAD      = 4'b1101,
    OP_NET_INDPTR   = 4'b1110,
    OP_NET_INDICES  = 4'b1111
  } opcode_e;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } fe_state_t;

  // One buffered core fire event; proc is sized to the 4-bit out_data field.
  typedef struct packed {
    logic [EVT_PROC_W-1:0] proc;
    logic [1:0]            startstop;
  } evt_t;

  // Opcodes 0011, 01xx and 1000 have no meaning in the core.
  function automatic logic is_reserved_op(input logic [3:0] op);
    return (op == 4'b0011) || (op[3:2] == 2'b01) || (op == 4'b1000);
  endfunction

endpackage

// File: rtl/ttt_event_fifo.sv
// Small synchronous FIFO for core fire events; drops pushes when full.
module ttt_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot in the same edge, so full+push+pop is legal.
  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign overflow_c = push_i && full_o && !do_pop;
  assign dout_o     = mem_q[rd_ptr_q];

  // Storage, power-of-two pointers wrap naturally, occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ttt_packet_frontend.sv
// Beat-serial instruction packet assembler/decoder plus fire-event buffer.
// Optional build macro TTT_FE_CHECKSUM_EN adds a trailing XOR checksum beat.
module ttt_packet_frontend
  import ttt_pkg::*;
#(
  parameter  int unsigned NUM_PROCESSORS  = 16,
  parameter  int unsigned NUM_CONNECTIONS = 256,
  parameter  int unsigned NEW_TOKEN_BITS  = 4,
  parameter  int unsigned TOKEN_BITS      = 8,
  parameter  int unsigned DURATION_BITS   = 8,
  parameter  int unsigned IN_WIDTH        = 4,
  parameter  int unsigned EVT_DEPTH       = 4,
  localparam int unsigned PROC_W          = $clog2(NUM_PROCESSORS),
  localparam int unsigned CONN_W          = $clog2(NUM_CONNECTIONS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_sop,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [3:0]                instruction,
  output logic [PROC_W-1:0]         processor_id,
  output logic [NEW_TOKEN_BITS-1:0] good_tokens,
  output logic [NEW_TOKEN_BITS-1:0] bad_tokens,
  output logic [NEW_TOKEN_BITS-1:0] prog_tokens,
  output logic [CONN_W-1:0]         connection_id,
  output logic [7:0]                prog_value,
  input  logic                      evt_valid,
  input  logic [PROC_W-1:0]         evt_proc,
  input  logic [1:0]                evt_startstop,
  input  logic [1:0]                stage,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                status
);

  localparam int unsigned BEATS = PKT_W / IN_WIDTH;
`ifdef TTT_FE_CHECKSUM_EN
  localparam int unsigned BEATS_TOTAL = BEATS + 1;
`else
  localparam int unsigned BEATS_TOTAL = BEATS;
`endif
  localparam int unsigned CNT_W  = $clog2(BEATS_TOTAL + 1);
  localparam int unsigned PROG_W = (TOKEN_BITS > DURATION_BITS) ? TOKEN_BITS : DURATION_BITS;

  fe_state_t         state_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [PKT_W-1:0]  pkt_q;
  logic [PKT_W-1:0]  instr_q;
  logic              in_ready_q;
  logic              instr_valid_q;
  logic              frame_err_q;
  logic              bad_op_q;
  logic              evt_ovf_q;

  logic              beat_take;
  logic [CNT_W-1:0]  beat_idx;
  logic [PKT_W-1:0]  pkt_nxt;
`ifdef TTT_FE_CHECKSUM_EN
  logic [IN_WIDTH-1:0] csum_q;
  logic [IN_WIDTH-1:0] csum_nxt;
`endif

  // Position of the incoming beat and the packet as it would look after it.
  always_comb begin
    beat_take = in_valid && in_ready_q && (in_sop || (beat_cnt_q != '0));
    beat_idx  = in_sop ? '0 : beat_cnt_q;
    pkt_nxt   = in_sop ? PKT_W'(in_data) : ((pkt_q << IN_WIDTH) | PKT_W'(in_data));
`ifdef TTT_FE_CHECKSUM_EN
    csum_nxt  = in_sop ? in_data : (csum_q ^ in_data);
`endif
  end

  // Collect/present FSM with registered handshake outputs and frame flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      beat_cnt_q    <= '0;
      pkt_q         <= '0;
      instr_q       <= '0;
      in_ready_q    <= 1'b1;
      instr_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      bad_op_q      <= 1'b0;
`ifdef TTT_FE_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      case (state_q)
        COLLECT: begin
          // A new sop abandons a partial packet; a headless beat is dropped.
          if (in_valid && in_sop && (beat_cnt_q != '0)) begin
            frame_err_q <= 1'b1;
          end
          if (in_valid && !in_sop && (beat_cnt_q == '0)) begin
            frame_err_q <= 1'b1;
          end
          if (beat_take) begin
            if (beat_idx == CNT_W'(BEATS_TOTAL - 1)) begin
              beat_cnt_q <= '0;
`ifdef TTT_FE_CHECKSUM_EN
              if (in_data != csum_q) begin
                frame_err_q <= 1'b1;
              end else if (is_reserved_op(pkt_q[15:12])) begin
                bad_op_q <= 1'b1;
              end else begin
                instr_q       <= pkt_q;
                state_q       <= PRESENT;
                in_ready_q    <= 1'b0;
                instr_valid_q <= 1'b1;
              end
`else
              if (is_reserved_op(pkt_nxt[15:12])) begin
                bad_op_q <= 1'b1;
              end else begin
                instr_q       <= pkt_nxt;
                state_q       <= PRESENT;
                in_ready_q    <= 1'b0;
                instr_valid_q <= 1'b1;
              end
`endif
            end else begin
              beat_cnt_q <= CNT_W'(beat_idx + 1'b1);
              pkt_q      <= pkt_nxt;
`ifdef TTT_FE_CHECKSUM_EN
              csum_q     <= csum_nxt;
`endif
            end
          end
        end
        PRESENT: begin
          if (instr_ready) begin
            state_q       <= COLLECT;
            in_ready_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= COLLECT;
          in_ready_q    <= 1'b1;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Field buses decode straight from the held packet register.
  assign in_ready      = in_ready_q;
  assign instr_valid   = instr_valid_q;
  assign instruction   = instr_q[15:12];
  assign processor_id  = PROC_W'(instr_q[11:8]);
  assign good_tokens   = NEW_TOKEN_BITS'(instr_q[7:4]);
  assign bad_tokens    = NEW_TOKEN_BITS'(instr_q[3:0]);
  assign prog_tokens   = NEW_TOKEN_BITS'(instr_q[11:8]);
  assign connection_id = CONN_W'(instr_q[7:0]);
  // Program value limited to the widest of the threshold/duration fields.
  assign prog_value    = 8'(PROG_W'(instr_q[7:0]));

  evt_t evt_in;
  evt_t evt_head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic fifo_ovf_c;

  // Pack the incoming event into the buffered payload.
  always_comb begin
    evt_in.proc      = EVT_PROC_W'(evt_proc);
    evt_in.startstop = evt_startstop;
  end

  assign fifo_pop = out_valid && out_ready;

  ttt_event_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH ($bits(evt_t))
  ) u_evt_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (evt_valid),
    .din_i      (evt_in),
    .pop_i      (fifo_pop),
    .dout_o     (evt_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_c (fifo_ovf_c)
  );

  // Sticky overflow flag: an event arrived with no room and no pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_ovf_q <= 1'b0;
    end else if (fifo_ovf_c && fifo_full) begin
      evt_ovf_q <= 1'b1;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = {4'(evt_head.proc), evt_head.startstop, stage};
  assign status    = {evt_ovf_q, bad_op_q, frame_err_q};

endmodule

// File: tb/tb_ttt_packet_frontend.sv
// Scoreboard bench for ttt_packet_frontend (honours TTT_FE_CHECKSUM_EN).
`timescale 1ns/1ps
module tb_ttt_packet_frontend;

  localparam int unsigned IW    = 4;
  localparam int unsigned BEATS = 16 / IW;
  localparam int unsigned DEPTH = 4;
`ifdef TTT_FE_CHECKSUM_EN
  localparam bit          CSUM  = 1'b1;
  localparam int unsigned BEATS_TOTAL = BEATS + 1;
`else
  localparam bit          CSUM  = 1'b0;
  localparam int unsigned BEATS_TOTAL = BEATS;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_sop = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [3:0]    instruction;
  logic [3:0]    processor_id;
  logic [3:0]    good_tokens;
  logic [3:0]    bad_tokens;
  logic [3:0]    prog_tokens;
  logic [7:0]    connection_id;
  logic [7:0]    prog_value;
  logic          evt_valid = 1'b0;
  logic [3:0]    evt_proc = '0;
  logic [1:0]    evt_startstop = '0;
  logic [1:0]    stage = '0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    status;

  int checks = 0;
  int errors = 0;

  // Reference state: expected instructions, expected events, expected flags.
  logic [15:0] iq[$];
  logic [5:0]  eq[$];
  bit exp_fe = 0, exp_bad = 0, exp_ovf = 0;
  bit in_prog = 0;
  int ir_mode = 1, or_mode = 1;
  bit evt_rand = 0;
  int dir_req = 0, dir_done = 0;

  ttt_packet_frontend #(
    .IN_WIDTH (IW),
    .EVT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sop(in_sop), .in_valid(in_valid), .in_ready(in_ready),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .processor_id(processor_id),
    .good_tokens(good_tokens), .bad_tokens(bad_tokens), .prog_tokens(prog_tokens),
    .connection_id(connection_id), .prog_value(prog_value),
    .evt_valid(evt_valid), .evt_proc(evt_proc), .evt_startstop(evt_startstop),
    .stage(stage), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit op_ok(input logic [3:0] op);
    return (op <= 4'd2) || (op >= 4'd9);
  endfunction

  function automatic logic [35:0] exp_fields(input logic [15:0] p);
    return {p[15:12], p[11:8], p[7:4], p[3:0], p[11:8], p[7:0], p[7:0]};
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic check_status(input string name);
    check(name, 64'(status), 64'({exp_ovf, exp_bad, exp_fe}));
  endtask

  // Hold a beat until the DUT takes it (bounded).
  task automatic put_beat(input logic [IW-1:0] d, input logic sop);
    int   n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_sop = sop;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_accept actual=timeout required=accepted");
    end
    sync();
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  // Send the first nsend beats of packet p; predict its outcome when complete.
  task automatic send_pkt(input logic [15:0] p, input int nsend, input bit bad_cs);
    logic [IW-1:0] cs = '0;
    logic [IW-1:0] b;
    if (in_prog) exp_fe = 1;
    for (int i = 0; i < int'(BEATS_TOTAL) && i < nsend; i++) begin
      if (i < int'(BEATS)) begin
        b  = p[15 - i*IW -: IW];
        cs = cs ^ b;
      end else begin
        b = bad_cs ? (cs ^ IW'(1)) : cs;
      end
      if (i > 0 && $urandom_range(0, 7) == 0) idle(1);
      put_beat(b, i == 0);
    end
    if (nsend >= int'(BEATS_TOTAL)) begin
      in_prog = 0;
      if (CSUM && bad_cs) exp_fe = 1;
      else if (!op_ok(p[15:12])) exp_bad = 1;
      else iq.push_back(p);
    end else begin
      in_prog = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    idle(3);
    exp_fe = 0; exp_bad = 0; in_prog = 0;
    rst_n = 1'b1;
  endtask

  // Ready / stage / event stimulus.
  initial begin
    forever begin
      sync();
      stage       = 2'($urandom);
      instr_ready = (ir_mode == 2) ? 1'($urandom_range(0, 1)) : (ir_mode == 1);
      out_ready   = (or_mode == 2) ? 1'($urandom_range(0, 1)) : (or_mode == 1);
      if (dir_done < dir_req) begin
        evt_valid = 1'b1; evt_proc = 4'(dir_done + 1); evt_startstop = 2'(dir_done);
        dir_done++;
      end else if (evt_rand) begin
        evt_valid = ($urandom_range(0, 2) == 0);
        evt_proc = 4'($urandom); evt_startstop = 2'($urandom);
      end else begin
        evt_valid = 1'b0;
      end
    end
  end

  // Instruction monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        iq.delete();
      end else begin
        check("instr_valid", 64'(instr_valid), 64'(iq.size() != 0));
        check("in_ready", 64'(in_ready), 64'(iq.size() == 0));
        if (instr_valid && iq.size() != 0) begin
          check("fields", 64'({instruction, processor_id, good_tokens, bad_tokens,
                               prog_tokens, connection_id, prog_value}),
                64'(exp_fields(iq[0])));
          if (instr_ready) void'(iq.pop_front());
        end
      end
    end
  end

  // Event FIFO monitor and model.
  initial begin
    bit full, pop;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eq.delete();
        exp_ovf = 0;
      end else begin
        full = (eq.size() == DEPTH);
        check("out_valid", 64'(out_valid), 64'(eq.size() != 0));
        pop = (eq.size() != 0) && out_ready;
        if (pop) begin
          check("evt_head", 64'(out_data[7:2]), 64'(eq[0]));
          check("stage_pass", 64'(out_data[1:0]), 64'(stage));
          void'(eq.pop_front());
        end
        if (evt_valid) begin
          if (!full || pop) eq.push_back({evt_proc, evt_startstop});
          else exp_ovf = 1;
        end
      end
    end
  end

  initial begin
    int r, n, guard;
    idle(4);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_fields", 64'({instruction, processor_id, connection_id}), 64'd0);
    sync();

    // Basic decode, then hold PRESENT with a pending beat.
    ir_mode = 0;
    idle(1);
    send_pkt(16'h93A5, BEATS_TOTAL, 0);
    @(negedge clk);
    check("t1_decode", 64'({instr_valid, instruction, processor_id, prog_value}),
          64'({1'b1, 4'b1001, 4'd3, 8'hA5}));
    sync();
    in_valid = 1'b1; in_sop = 1'b1; in_data = IW'(7);
    idle(5);
    in_valid = 1'b0; in_sop = 1'b0;
    ir_mode = 1;
    idle(3);
    check_status("t2_status");

    // Interrupted packet followed by a good one.
    send_pkt(16'h1111, 2, 0);
    send_pkt(16'h2345, BEATS_TOTAL, 0);
    idle(3);
    check("t3_frame_err", 64'(status[0]), 64'd1);
    check_status("t3_status");

    // Reserved opcode.
    send_pkt(16'h4123, BEATS_TOTAL, 0);
    idle(3);
    check("t4_bad_op", 64'(status[1]), 64'd1);
    check_status("t4_status");

    // Overflow the event FIFO, then drain.
    or_mode = 0;
    idle(2);
    dir_req = dir_done + 5;
    idle(8);
    check("t5_overflow", 64'(status[2]), 64'd1);
    check("t5_out_valid", 64'(out_valid), 64'd1);
    or_mode = 1;
    idle(8);
    check("t5_drained", 64'(out_valid), 64'd0);

`ifdef TTT_FE_CHECKSUM_EN
    do_reset();
    send_pkt(16'h1234, BEATS_TOTAL, 0);
    idle(3);
    check("t6_good_csum", 64'(status[0]), 64'd0);
    send_pkt(16'h1234, BEATS_TOTAL, 1);
    idle(3);
    check("t6_bad_csum", 64'(status[0]), 64'd1);
`endif

    // Reset while presenting, then reset mid-packet.
    ir_mode = 0;
    send_pkt(16'h1000, BEATS_TOTAL, 0);
    idle(2);
    do_reset();
    ir_mode = 1;
    send_pkt(16'h2456, 2, 0);
    do_reset();
    send_pkt(16'h0ABC, BEATS_TOTAL, 0);
    idle(4);
    check_status("t7_status");
    check("t7_idle", 64'(instr_valid), 64'd0);

    // Randomised traffic.
    ir_mode = 2; or_mode = 2; evt_rand = 1;
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0 && !in_prog) begin
        put_beat(IW'($urandom), 1'b0);
        exp_fe = 1;
      end else begin
        n = (r < 3) ? int'($urandom_range(1, BEATS_TOTAL - 1)) : int'(BEATS_TOTAL);
        send_pkt(16'($urandom), n, CSUM && (r == 3 || r == 4));
      end
    end
    if (in_prog) send_pkt(16'h2000, BEATS_TOTAL, 0);
    evt_rand = 0; ir_mode = 1; or_mode = 1;
    guard = 0;
    while ((iq.size() != 0 || eq.size() != 0) && guard < 200) begin
      sync();
      guard++;
    end
    check("drain_done", 64'(guard < 200), 64'd1);
    idle(2);
    check_status("final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttt_packet_frontend.md
Name: ttt_packet_frontend

Overview:
Parametrised successor to the fixed 16-bit parallel instruction wrapper of the tick-tock-tokens design. It assembles instruction packets from a narrow beat-serial input (IN_WIDTH bits per beat) with a valid/ready handshake. It decodes each packet into the opcode and field buses driven into tt_um_jleugeri_ttt_main. Core fire events are buffered in a small FIFO so that none are lost while the host is not reading.

Parameters:
NUM_PROCESSORS, 16, processor count; PROC_W = $clog2(NUM_PROCESSORS)
NUM_CONNECTIONS, 256, connection count; CONN_W = $clog2(NUM_CONNECTIONS)
NEW_TOKEN_BITS, 4, width of the token-delta fields
TOKEN_BITS, 8, width of the threshold field
DURATION_BITS, 8, width of the duration field
IN_WIDTH, 4, bits per input beat; must divide 16; BEATS = 16/IN_WIDTH
EVT_DEPTH, 4, event FIFO depth; power of two, at least 2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_data  in  IN_WIDTH  packet beat, MSB beat first
in_sop  in  1  marks the first beat of a packet
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&in_ready
instr_valid  out  1  decoded instruction presented to the core
instr_ready  in  1  core accepts the instruction
instruction  out  4  opcode, packet[15:12]
processor_id  out  PROC_W  packet[11:8] truncated or zero-extended
good_tokens  out  NEW_TOKEN_BITS  packet[7:4]
bad_tokens  out  NEW_TOKEN_BITS  packet[3:0]
prog_tokens  out  NEW_TOKEN_BITS  packet[11:8]
connection_id  out  CONN_W  packet[7:0] resized
prog_value  out  8  packet[7:0]; drives threshold and duration
evt_valid  in  1  core fire event
evt_proc  in  PROC_W  firing processor
evt_startstop  in  2  start/stop token bits
stage  in  2  core execution stage
out_data  out  8  {4'(fifo_proc), fifo_startstop, stage}
out_valid  out  1  FIFO not empty
out_ready  in  1  pop the FIFO head
status  out  3  sticky flags {evt_overflow, bad_opcode, frame_err}

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM enters COLLECT; beat counter = 0; FIFO empty; all flags = 0; instr_valid = 0; out_valid = 0; in_ready = 1; field outputs = 0.
- FSM COLLECT:
  - in_ready = 1.
  - Each accepted beat is shifted into the packet register and increments beat_cnt.
  - An accepted beat with in_sop=1 forces beat_cnt := 1 with that beat as the MSBs. If beat_cnt was nonzero, frame_err is set and the partial packet is discarded.
  - A beat with in_sop=0 when beat_cnt=0 is dropped and sets frame_err.
  - When beat BEATS-1 is accepted, the opcode is checked:
    - Valid opcodes (0000, 0001, 0010, 1001–1111): go to PRESENT on the next edge.
    - Reserved opcodes (0011, 01xx, 1000): packet dropped, bad_opcode set, FSM stays in COLLECT.
- FSM PRESENT:
  - in_ready = 0; instr_valid = 1; the field buses hold the registered packet and stay stable.
  - instr_ready=1 completes the transfer on that edge and returns the FSM to COLLECT.
  - Latency from the last accepted beat to instr_valid = 1 cycle. Back-to-back throughput is BEATS+1 cycles per packet.
- Opcode 0000 (no-op) is still presented to the core; the core relies on it for stage hold.
- Event FIFO:
  - A push occurs on evt_valid; a pop occurs on out_valid&out_ready.
  - Simultaneous push and pop when full is legal; the count is unchanged.
  - Push when full without a pop: the new event is dropped and evt_overflow is set.
  - Pointers wrap modulo EVT_DEPTH; the count is EVT_DEPTH+1 states wide.
  - stage in out_data is a live pass-through, not buffered.
- Sticky flags clear only on reset.
- Reset mid-packet or mid-PRESENT discards all state; no instruction is emitted.

Optional Feature:
TTT_FE_CHECKSUM_EN:
- With the macro defined: each packet carries one extra trailing beat, the XOR of all IN_WIDTH-wide packet beats.
- On a mismatch the packet is dropped and frame_err is set; the opcode is not checked.
- BEATS_TOTAL = BEATS+1.
- Without the macro: there is no checksum beat and BEATS_TOTAL = BEATS.

Decomposition:
- Package ttt_pkg holds:
  - opcode enum: OP_NOP, OP_INPUT, OP_ADVANCE, OP_PROG_DUR, OP_PROG_GOOD_TH, OP_PROG_BAD_TH, OP_NET_GOOD, OP_NET_BAD, OP_NET_INDPTR, OP_NET_INDICES
  - function is_reserved_op()
  - fe_state_t {COLLECT, PRESENT}
  - event struct {proc, startstop}
- One sub-module, ttt_event_fifo: parametrised DEPTH and WIDTH, with push/pop/full/empty/overflow ports.

Test Plan:
1. IN_WIDTH=4, beats 0x9 (sop), 0x3, 0xA, 0x5 → after the 4th beat, 1 cycle later: instr_valid=1, instruction=1001, processor_id=3, prog_value=0xA5. instr_ready=1 → back in COLLECT, in_ready=1.
2. Hold instr_ready=0 for 5 cycles during PRESENT → fields stable, in_ready=0, extra beats not accepted.
3. sop, 2 beats, then a new sop → frame_err=1, first packet discarded, second packet decoded correctly.
4. Packet 0x4123 (reserved opcode) → no instr_valid, bad_opcode=1.
5. 5 evt_valid pulses (proc 1..5) with out_ready=0, EVT_DEPTH=4 → evt_overflow=1. Draining yields procs 1,2,3,4 in order; then out_valid=0.
6. With TTT_FE_CHECKSUM_EN: packet 0x1234 with checksum beat 0x4 → accepted. The same packet with checksum 0x5 → dropped, frame_err=1.
